// File: rtl/apb4_slave_ws_pkg.sv
// Shared types and constants for the APB4 wait-state completer.
package apb4_slave_ws_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam int unsigned MAX_WAIT = 15;
    localparam int unsigned CNT_W    = 4;

    // Ceiling log2 that is usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/apb4_slave_ws_if.sv
// APB4 requester/completer signal bundle.
interface apb4_slave_ws_if #(
    parameter int unsigned AWD = 16,
    parameter int unsigned DWD = 32
);
    logic [AWD-1:0]   paddr;
    logic             psel;
    logic             penable;
    logic             pwrite;
    logic [DWD-1:0]   pwdata;
    logic [DWD/8-1:0] pstrb;
    logic [DWD-1:0]   prdata;
    logic             pready;
    logic             pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb4_slave_ws_addr_chk.sv
// Window and alignment check; also produces the window-relative address.
module apb4_slave_ws_addr_chk
    import apb4_slave_ws_pkg::*;
#(
    parameter int unsigned    AWD  = 16,
    parameter int unsigned    DWD  = 32,
    parameter logic [AWD-1:0] BASE = '0,
    parameter int unsigned    SPAN = 'h100
) (
    input  logic [AWD-1:0] paddr,
    input  logic           psel,
    input  logic           penable,
    output logic           err_c,
    output logic [AWD-1:0] addr_c
);
    localparam int unsigned    AW1   = AWD + 1;
    localparam int unsigned    LSB   = clog2(DWD / 8);
    localparam logic [AWD-1:0] AMASK = AWD'((32'd1 << LSB) - 32'd1);

    logic [AW1-1:0] off;
    logic           oow;
    logic           mis;

    // One extra bit keeps the borrow, so addresses below BASE wrap high and fail the span test.
    assign off    = AW1'(paddr) - AW1'(BASE);
    assign oow    = off >= AW1'(SPAN);
    assign mis    = (paddr & AMASK) != '0;
    assign err_c  = psel & penable & (oow | mis);
    assign addr_c = off[AWD-1:0];
endmodule

// File: rtl/apb4_slave_ws.sv
// APB4 completer with programmable read/write wait states, byte strobes,
// window/alignment error response and abort on psel drop.
module apb4_slave_ws
    import apb4_slave_ws_pkg::*;
#(
    parameter int unsigned    AWD   = 16,
    parameter int unsigned    DWD   = 32,
    parameter int unsigned    RWAIT = 2,
    parameter int unsigned    WWAIT = 0,
    parameter logic [AWD-1:0] BASE  = '0,
    parameter int unsigned    SPAN  = 'h100
) (
    input  logic              pclk,
    input  logic              reset,
    apb4_slave_ws_if.slave    bus,
    output logic [AWD-1:0]    addr,
    output logic              wr,
    output logic              rd,
    output logic [DWD-1:0]    wdata,
    output logic [DWD/8-1:0]  wstrb,
    input  logic [DWD-1:0]    rdata
);
    if (!(DWD == 8 || DWD == 16 || DWD == 32 || DWD == 64)) begin : g_bad_dwd
        $fatal(1, "apb4_slave_ws: DWD must be 8, 16, 32 or 64");
    end
    if (RWAIT > MAX_WAIT || WWAIT > MAX_WAIT) begin : g_bad_wait
        $fatal(1, "apb4_slave_ws: RWAIT/WWAIT must not exceed 15");
    end

    localparam logic [CNT_W-1:0] RW = CNT_W'(RWAIT);
    localparam logic [CNT_W-1:0] WW = CNT_W'(WWAIT);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             acc_c;
    logic             err_c;
    logic [CNT_W-1:0] wait_c;

    apb4_slave_ws_addr_chk #(
        .AWD  (AWD),
        .DWD  (DWD),
        .BASE (BASE),
        .SPAN (SPAN)
    ) u_addr_chk (
        .paddr   (bus.paddr),
        .psel    (bus.psel),
        .penable (bus.penable),
        .err_c   (err_c),
        .addr_c  (addr)
    );

    assign acc_c  = bus.psel & bus.penable;
    assign wait_c = bus.pwrite ? WW : RW;
    assign wdata  = bus.pwdata;
    assign wstrb  = bus.pwrite ? bus.pstrb : '0;

    // State and wait counter; cnt holds the waits still to go after this cycle.
    always_ff @(posedge pclk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (acc_c && !err_c && wait_c != '0) begin
                        state <= ST_WAIT;
                        cnt   <= wait_c - CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (!bus.psel) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Response and back-end strobes, all forced low while reset is held.
    always_comb begin
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        bus.prdata  = '0;
        wr          = 1'b0;
        rd          = 1'b0;
        if (!reset) begin
            case (state)
                ST_IDLE: begin
                    if (acc_c) begin
                        if (err_c) begin
                            bus.pready  = 1'b1;
                            bus.pslverr = 1'b1;
                        end else begin
                            rd = !bus.pwrite;
                            if (wait_c == '0) begin
                                bus.pready = 1'b1;
                                wr         = bus.pwrite;
                                if (!bus.pwrite) bus.prdata = rdata;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.psel && cnt == '0) begin
                        bus.pready = 1'b1;
                        wr         = bus.pwrite;
                        if (!bus.pwrite) bus.prdata = rdata;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_apb4_slave_ws.sv
// Bench for apb4_slave_ws: three instances with different wait settings
// share one APB driver; psel selects which instance takes the transfer.
module tb_apb4_slave_ws;
    localparam int unsigned AWD    = 16;
    localparam int unsigned DWD    = 32;
    localparam int          BASE_I = 'h100;
    localparam int          SPAN_I = 'h100;
    localparam int          NDUT   = 3;

    int rwv [NDUT] = '{2, 3, 1};
    int wwv [NDUT] = '{0, 4, 1};

    logic           pclk = 1'b0;
    logic           reset;
    logic [1:0]     sel;
    logic [AWD-1:0] paddr;
    logic           psel, penable, pwrite;
    logic [DWD-1:0] pwdata, rdata;
    logic [3:0]     pstrb;

    logic           o_pready  [NDUT];
    logic           o_pslverr [NDUT];
    logic [DWD-1:0] o_prdata  [NDUT];
    logic [AWD-1:0] o_addr    [NDUT];
    logic           o_wr      [NDUT];
    logic           o_rd      [NDUT];
    logic [DWD-1:0] o_wdata   [NDUT];
    logic [3:0]     o_wstrb   [NDUT];

    int total = 0;
    int bad   = 0;

    always #5 pclk = ~pclk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        apb4_slave_ws_if #(.AWD(AWD), .DWD(DWD)) bus ();
        assign bus.paddr   = paddr;
        assign bus.psel    = psel && (sel == 2'(g));
        assign bus.penable = penable;
        assign bus.pwrite  = pwrite;
        assign bus.pwdata  = pwdata;
        assign bus.pstrb   = pstrb;
        assign o_pready[g]  = bus.pready;
        assign o_pslverr[g] = bus.pslverr;
        assign o_prdata[g]  = bus.prdata;

        apb4_slave_ws #(
            .AWD   (AWD),
            .DWD   (DWD),
            .RWAIT (g == 0 ? 2 : (g == 1 ? 3 : 1)),
            .WWAIT (g == 0 ? 0 : (g == 1 ? 4 : 1)),
            .BASE  (16'h0100),
            .SPAN  ('h100)
        ) u_dut (
            .pclk  (pclk),
            .reset (reset),
            .bus   (bus),
            .addr  (o_addr[g]),
            .wr    (o_wr[g]),
            .rd    (o_rd[g]),
            .wdata (o_wdata[g]),
            .wstrb (o_wstrb[g]),
            .rdata (rdata)
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference rule: legal only inside the window and word aligned.
    function automatic bit exp_err(input int a);
        return (a < BASE_I) || (a >= BASE_I + SPAN_I) || (a % (DWD / 8) != 0);
    endfunction

    // One complete transfer starting with a setup phase on the next edge.
    task automatic xfer(input int d, input bit w, input int a, input logic [31:0] wd,
                        input logic [3:0] st, input logic [31:0] rdv);
        bit  err;
        int  lat;
        int  nwr;
        int  nrd;
        bit  done;
        err  = exp_err(a);
        lat  = err ? 0 : (w ? wwv[d] : rwv[d]);
        nwr  = 0;
        nrd  = 0;
        done = 1'b0;
        @(posedge pclk); #1;
        sel = 2'(d); psel = 1'b1; penable = 1'b0; pwrite = w;
        paddr = 16'(a); pwdata = wd; pstrb = st; rdata = rdv;
        @(negedge pclk);
        chk("setup_pready", 32'(o_pready[d]), 32'd0);
        chk("setup_rd", 32'(o_rd[d]), 32'd0);
        @(posedge pclk); #1;
        penable = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge pclk);
            if (o_wr[d]) begin
                nwr++;
                chk("wr_with_ready", 32'(o_pready[d]), 32'd1);
            end
            if (o_rd[d]) begin
                nrd++;
                chk("rd_first_cycle", 32'(c), 32'd0);
            end
            if (o_pready[d]) begin
                done = 1'b1;
                chk("latency", 32'(c), 32'(lat));
                chk("pslverr", 32'(o_pslverr[d]), 32'(err));
                chk("prdata", o_prdata[d], (!w && !err) ? rdv : 32'd0);
                if (!err) begin
                    chk("addr", 32'(o_addr[d]), 32'(a - BASE_I));
                    chk("wstrb", 32'(o_wstrb[d]), w ? 32'(st) : 32'd0);
                    if (w) chk("wdata", o_wdata[d], wd);
                end
            end else begin
                chk("prdata_idle", o_prdata[d], 32'd0);
            end
        end
        chk("ready_seen", 32'(done), 32'd1);
        chk("wr_count", 32'(nwr), (w && !err) ? 32'd1 : 32'd0);
        chk("rd_count", 32'(nrd), (!w && !err) ? 32'd1 : 32'd0);
    endtask

    task automatic idle();
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sel = 2'd0; psel = 1'b1; penable = 1'b1; pwrite = 1'b0;
        paddr = 16'(BASE_I + SPAN_I); pwdata = '0; pstrb = '0; rdata = 32'hFFFF_FFFF;

        // Outputs stay quiet while reset is held, even with an erroring access on the bus.
        for (int i = 0; i < 2; i++) begin
            @(negedge pclk);
            chk("rst_pready", 32'(o_pready[0]), 32'd0);
            chk("rst_pslverr", 32'(o_pslverr[0]), 32'd0);
            chk("rst_wr_rd", 32'({o_wr[0], o_rd[0]}), 32'd0);
            chk("rst_prdata", o_prdata[0], 32'd0);
        end
        @(posedge pclk); #1;
        reset = 1'b0; psel = 1'b0; penable = 1'b0;

        xfer(0, 1'b0, BASE_I + 'h8, 32'h0, 4'h0, 32'hCAFE_0001);
        idle();
        xfer(0, 1'b1, BASE_I + 'h4, 32'h1234_5678, 4'b0101, 32'h0);
        idle();
        xfer(0, 1'b1, BASE_I + SPAN_I, 32'hDEAD_BEEF, 4'hF, 32'h0);
        idle();
        xfer(0, 1'b0, BASE_I + 'h2, 32'h0, 4'h0, 32'h5555_AAAA);
        idle();
        xfer(1, 1'b0, BASE_I - 4, 32'h0, 4'h0, 32'h1111_2222);
        idle();
        xfer(2, 1'b1, BASE_I + SPAN_I - 4, 32'hA5A5_0000, 4'b1000, 32'h0);
        idle();

        // Abort: read on the 3-wait instance, psel dropped after two access cycles.
        @(posedge pclk); #1;
        sel = 2'd1; psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
        paddr = 16'(BASE_I + 'h20); rdata = 32'h0BAD_F00D;
        @(posedge pclk); #1;
        penable = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge pclk);
            chk("abort_no_ready", 32'(o_pready[1]), 32'd0);
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge pclk);
            chk("abort_quiet", 32'({o_pready[1], o_wr[1], o_rd[1]}), 32'd0);
        end
        xfer(1, 1'b1, BASE_I + 'h24, 32'h7777_8888, 4'hF, 32'h0);
        idle();

        // Reset during the wait phase of a 4-wait write must suppress wr.
        @(posedge pclk); #1;
        sel = 2'd1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 16'(BASE_I + 'h10); pwdata = 32'h0F0F_0F0F; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge pclk);
            chk("pre_reset_quiet", 32'({o_pready[1], o_wr[1]}), 32'd0);
        end
        @(posedge pclk); #1;
        reset = 1'b1;
        @(negedge pclk);
        chk("mid_reset_quiet", 32'({o_pready[1], o_wr[1], o_rd[1]}), 32'd0);
        chk("mid_reset_prdata", o_prdata[1], 32'd0);
        @(posedge pclk); #1;
        reset = 1'b0; psel = 1'b0; penable = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge pclk);
            chk("post_reset_no_wr", 32'(o_wr[1]), 32'd0);
        end
        xfer(0, 1'b0, BASE_I + 'h30, 32'h0, 4'h0, 32'h2468_ACE0);
        idle();

        // Back-to-back write then read on the 1/1-wait instance.
        xfer(2, 1'b1, BASE_I + 'h40, 32'hFEED_FACE, 4'b0011, 32'h0);
        xfer(2, 1'b0, BASE_I + 'h44, 32'h0, 4'h0, 32'h1357_9BDF);
        idle();

        // Randomised transfers around the window edges, with and without idle gaps.
        for (int n = 0; n < 40; n++) begin
            int  d;
            int  a;
            bit  w;
            d = int'($urandom_range(0, NDUT - 1));
            w = 1'($urandom_range(0, 1));
            a = BASE_I - 8 + int'($urandom_range(0, SPAN_I + 15));
            if ($urandom_range(0, 3) != 0) a = a & ~3;
            xfer(d, w, a, $urandom, 4'($urandom), $urandom);
            if ($urandom_range(0, 1) != 0) idle();
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
